arm_boot_loader: RTL and testbench
==================================

# arm_boot_loader

Boot/load controller for the ARM core and its dual-port memory. It owns memory port 2 while a program image is streamed in word by word, and holds the core in reset during the load. After the load it releases the core, hands port 2 to the core's data path, and watches `halted` to report completion. This replaces ad-hoc program loading in the benches and feeds `arm_memory` port 2 and `arm_core` reset directly.

## Interface
Parameters:
- `MEM_WORDS`, 1024: maximum image size in 32-bit words.
- `BASE_ADDR`, 32'h0: byte address of the first loaded word.
- `RST_HOLD`, 4: cycles the core stays in reset after the last word is written, before release.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a load.
- `ld_valid` in 1: image word valid.
- `ld_data` in 32: image word.
- `ld_last` in 1: marks the final image word; qualified by `ld_valid`.
- `ld_ready` out 1: loader accepts a word this cycle.
- `chk_exp` in 32: expected XOR checksum of the image. Used only when `BOOT_CHECKSUM_EN` is defined.
- `core_halted` in 1: `halted` from `arm_core`.
- `core_mem_addr` in 32: core data address.
- `core_mem_data_in` in 32: core store data.
- `core_mem_write_en` in 1: core store enable.
- `mem_addr` out 32: to `arm_memory` `addr2`.
- `mem_data_in` out 32: to `arm_memory` `data_in2`.
- `mem_write_en` out 1: to `arm_memory` `we[1]`.
- `core_rst` out 1: active-high reset to `arm_core`.
- `busy` out 1: asserted in LOAD or HOLD.
- `done` out 1: asserted in DONE.
- `err` out 1: asserted in ERR.
- `load_count` out 16: number of words accepted in the current or last load.

## Operation
States: IDLE, LOAD, HOLD, RUN, DONE, ERR.

- **IDLE**
  - `core_rst`=1, `ld_ready`=0, loader drives the memory port with `mem_write_en`=0.
  - `start` → LOAD; clears `load_count`, the checksum accumulator and `err`.
- **LOAD**
  - `ld_ready`=1.
  - Each `ld_valid`&&`ld_ready` beat registers `mem_addr`=`BASE_ADDR`+4·`load_count`, `mem_data_in`=`ld_data` and `mem_write_en`=1 for exactly one cycle. `load_count` increments and the checksum updates as acc ^= `ld_data`.
  - Beat with `ld_last` → HOLD.
  - Beat at `load_count`==`MEM_WORDS`−1 without `ld_last` → ERR. That word is still written.
  - Cycles without a beat drive `mem_write_en`=0.
- **HOLD**
  - `core_rst`=1, `ld_ready`=0.
  - Counts `RST_HOLD` cycles, then → RUN. With `BOOT_CHECKSUM_EN`, a checksum mismatch sends it to ERR instead.
- **RUN**
  - `core_rst`=0.
  - `mem_addr`, `mem_data_in` and `mem_write_en` are combinationally muxed from the `core_mem_*` inputs.
  - `core_halted` → DONE.
- **DONE**
  - `core_rst`=1 (freezes the core), `done`=1.
  - `start` → LOAD.
- **ERR**
  - `core_rst`=1, `err`=1, `mem_write_en`=0.
  - `start` → LOAD.

Boundary rules:
- `start` is ignored in LOAD, HOLD and RUN.
- `ld_valid` outside LOAD is ignored; no write occurs.
- `load_count` saturates at `MEM_WORDS` and holds its value after the load.
- `ld_last` on the first beat is legal: a one-word image.

## Timing
- Reset (async assert, synchronous release by flop): state IDLE, `core_rst`=1, all other outputs 0, `load_count`=0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to IDLE, with `mem_write_en` deasserted asynchronously.
- Write latency: a beat accepted at edge N produces `mem_write_en`=1 with its address and data during cycle N+1.
- The last write completes before HOLD counting begins.
- Core reset release: `core_rst` falls `RST_HOLD`+1 cycles after the `ld_last` beat edge.
- RUN mux has zero latency. The transition to DONE takes one cycle after `core_halted` is sampled high. A core store in that same cycle still passes through.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - 32-bit XOR accumulator over accepted words.
  - Compared to `chk_exp` on HOLD exit; mismatch → ERR with `core_rst` held at 1.
- Undefined:
  - No accumulator; `chk_exp` is ignored.
  - HOLD always proceeds to RUN.

## Test plan
- Reset with `rst_n`=0 → `core_rst`=1, `ld_ready`=0, `mem_write_en`=0, `load_count`=0.
- `start`, then 3 words 0xE3A00001/0xE2800002/0xEF000000 (last on the third), `BASE_ADDR`=0 → writes to addresses 0/4/8, one cycle after each beat; `core_rst` falls 5 cycles after the third beat (`RST_HOLD`=4).
- In RUN, core drives addr 0x40, data 0xDEADBEEF, we=1 → same values appear on the `mem_*` outputs in the same cycle. `core_halted`=1 → `done`=1 and `core_rst`=1 on the next cycle.
- `MEM_WORDS`=4, 4 beats without `ld_last` → 4 writes, then ERR, `err`=1, `load_count`=4. `start` → LOAD with `err`=0.
- `BOOT_CHECKSUM_EN` defined, words 0x1/0x2 with `chk_exp`=0x3 → RUN. Repeat with `chk_exp`=0x4 → ERR, core stays in reset.
- `rst_n` pulsed low mid-LOAD after 2 beats → immediate IDLE, `mem_write_en`=0, `load_count`=0. Beats with `ld_valid`=1 while IDLE → no writes.

Source files
------------

// File: rtl/arm_boot_loader.sv
// arm_boot_loader: streams a program image into memory port 2 with the core held in reset, then hands the port to the core.
// Optional `BOOT_CHECKSUM_EN` adds an XOR image check on HOLD exit.
module arm_boot_loader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [31:0] chk_exp,
  input  logic        core_halted,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_data_in,
  input  logic        core_mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] load_count
);
  localparam int HW = $clog2(RST_HOLD + 2);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [HW-1:0] r_hold;
  logic [15:0] r_cnt;
  logic [31:0] r_addr, r_data;
  logic r_we, w_start, w_beat, w_run, w_chk_ok;
  assign w_start = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_beat = ld_valid && r_state == LOAD;
  assign w_run = r_state == RUN;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] r_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else if (w_start) r_acc <= '0;
    else if (w_beat) r_acc <= r_acc ^ ld_data;
  assign w_chk_ok = r_acc == chk_exp;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^chk_exp;
  assign w_chk_ok = 1'b1;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = w_start ? LOAD : r_state;
      LOAD: if (w_beat) w_next = ld_last ? HOLD : (r_cnt == 16'(MEM_WORDS - 1)) ? ERR : LOAD;
      HOLD: if (r_hold == HW'(RST_HOLD)) w_next = w_chk_ok ? RUN : ERR;
      RUN:  if (core_halted) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // The first HOLD cycle carries the final write, so the hold count runs one cycle past RST_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == HOLD) ? r_hold + 1'b1 : '0;
      r_we    <= w_beat;
      if (w_beat) begin
        r_addr <= BASE_ADDR + {14'd0, r_cnt, 2'd0};
        r_data <= ld_data;
      end
      if (w_start) r_cnt <= '0;
      else if (w_beat && r_cnt != 16'(MEM_WORDS)) r_cnt <= r_cnt + 16'd1;
    end
  end
  assign mem_addr     = w_run ? core_mem_addr : r_addr;
  assign mem_data_in  = w_run ? core_mem_data_in : r_data;
  assign mem_write_en = w_run ? core_mem_write_en : r_we;
  assign core_rst     = !w_run;
  assign ld_ready     = r_state == LOAD;
  assign busy         = r_state == LOAD || r_state == HOLD;
  assign done         = r_state == DONE;
  assign err          = r_state == ERR;
  assign load_count   = r_cnt;
endmodule

// File: tb/tb_arm_boot_loader.sv
// tb_arm_boot_loader: directed sequence with randomized images and gaps, checked against an image-level model.
module tb_arm_boot_loader;
  localparam int          MW = 4;
  localparam int          RH = 4;
  localparam logic [31:0] BA = 32'h0;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0, chk_exp = '0, core_mem_addr = '0, core_mem_data_in = '0;
  logic core_halted = 1'b0, core_mem_write_en = 1'b0;
  logic ld_ready, mem_write_en, core_rst, busy, done, err;
  logic [31:0] mem_addr, mem_data_in;
  logic [15:0] load_count;
  logic [31:0] img [$];
  int n_chk = 0, n_err = 0;

  arm_boot_loader #(.MEM_WORDS(MW), .BASE_ADDR(BA), .RST_HOLD(RH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .chk_exp(chk_exp), .core_halted(core_halted),
    .core_mem_addr(core_mem_addr), .core_mem_data_in(core_mem_data_in),
    .core_mem_write_en(core_mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .core_rst(core_rst), .busy(busy), .done(done), .err(err),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  function automatic logic [31:0] img_xor();
    logic [31:0] a = '0;
    foreach (img[i]) a ^= img[i];
    return a;
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("start_ld_ready", ld_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_err_clr", err, 0);
    chk("start_cnt_clr", load_count, 0);
  endtask

  // Streams img with random gaps; each accepted word must appear as one write in the next cycle.
  task automatic stream(input bit last);
    int idx = 0;
    bit v;
    while (idx < img.size()) begin
      v = ($urandom_range(0, 2) != 0);
      chk("ld_ready", ld_ready, 1);
      start    = ($urandom_range(0, 3) == 0);
      ld_valid = v;
      ld_data  = v ? img[idx] : $urandom;
      ld_last  = v ? (last && idx == img.size() - 1) : 1'($urandom_range(0, 1));
      step;
      chk("wr_en", mem_write_en, 32'(v));
      if (v) begin
        chk("wr_addr", mem_addr, BA + 32'(4 * idx));
        chk("wr_data", mem_data_in, img[idx]);
        idx++;
      end
      chk("load_count", load_count, 32'(idx));
    end
    start = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic expect_release(input bit exp_run);
    core_mem_write_en = 1'b0;
    for (int i = 0; i < RH; i++) begin
      start = 1'($urandom_range(0, 1));
      step;
      chk("hold_core_rst", core_rst, 1);
      chk("hold_busy", busy, 1);
      chk("hold_ld_ready", ld_ready, 0);
      chk("hold_we", mem_write_en, 0);
    end
    start = 1'b0;
    step;
    chk("rel_busy", busy, 0);
    chk("rel_core_rst", core_rst, exp_run ? 0 : 1);
    chk("rel_err", err, exp_run ? 0 : 1);
  endtask

  task automatic run_phase(input logic [31:0] a0, input logic [31:0] d0);
    for (int k = 0; k < 3; k++) begin
      core_mem_addr     = (k == 0) ? a0 : $urandom;
      core_mem_data_in  = (k == 0) ? d0 : $urandom;
      core_mem_write_en = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = (k == 1);
      #1;
      chk("run_addr", mem_addr, core_mem_addr);
      chk("run_data", mem_data_in, core_mem_data_in);
      chk("run_we", mem_write_en, 32'(core_mem_write_en));
      step;
      start = 1'b0;
      chk("run_core_rst", core_rst, 0);
      chk("run_busy", busy, 0);
    end
    core_halted = 1'b1;
    core_mem_addr = $urandom;
    core_mem_data_in = $urandom;
    core_mem_write_en = 1'b1;
    #1;
    chk("halt_store_addr", mem_addr, core_mem_addr);
    chk("halt_store_we", mem_write_en, 1);
    step;
    core_halted = 1'b0;
    core_mem_write_en = 1'b0;
    chk("done", done, 1);
    chk("done_core_rst", core_rst, 1);
    chk("done_we", mem_write_en, 0);
  endtask

  task automatic idle_beats(input string tag);
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      ld_data = $urandom;
      step;
      chk(tag, mem_write_en, 0);
      chk("idle_ld_ready", ld_ready, 0);
      chk("idle_cnt", load_count, 0);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_cnt", load_count, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_addr", mem_addr, 0);
    repeat (2) step;
    rst_n = 1'b1;
    idle_beats("idle_no_write");

    img = '{32'hE3A00001, 32'hE2800002, 32'hEF000000};
    chk_exp = img_xor();
    pulse_start;
    stream(1'b1);
    expect_release(1'b1);
    run_phase(32'h40, 32'hDEADBEEF);

    img = '{$urandom, $urandom, $urandom, $urandom};
    pulse_start;
    stream(1'b0);
    chk("ovf_err", err, 1);
    chk("ovf_cnt", load_count, MW);
    chk("ovf_ld_ready", ld_ready, 0);
    ld_valid = 1'b1;
    ld_data = $urandom;
    step;
    ld_valid = 1'b0;
    chk("err_no_write", mem_write_en, 0);
    chk("err_hold", err, 1);
    chk("err_cnt_hold", load_count, MW);
    chk("err_core_rst", core_rst, 1);
    pulse_start;

    img = '{$urandom};
    chk_exp = img_xor();
    stream(1'b1);
    expect_release(1'b1);
    run_phase($urandom, $urandom);

    repeat (3) begin
      img.delete();
      repeat ($urandom_range(1, MW)) img.push_back($urandom);
      chk_exp = img_xor();
      pulse_start;
      stream(1'b1);
      expect_release(1'b1);
      run_phase($urandom, $urandom);
    end

    img = '{32'h1, 32'h2};
    chk_exp = 32'h3;
    pulse_start;
    stream(1'b1);
    expect_release(1'b1);
    run_phase($urandom, $urandom);
    chk_exp = 32'h4;
    pulse_start;
    stream(1'b1);
    expect_release(!CK);
    if (!CK) run_phase($urandom, $urandom);

    pulse_start;
    ld_valid = 1'b1;
    ld_data = 32'hA5A5_0001;
    step;
    ld_data = 32'hA5A5_0002;
    step;
    ld_valid = 1'b0;
    chk("mid_we", mem_write_en, 1);
    chk("mid_addr", mem_addr, BA + 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", mem_write_en, 0);
    chk("abort_cnt", load_count, 0);
    chk("abort_ld_ready", ld_ready, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_busy", busy, 0);
    step;
    rst_n = 1'b1;
    idle_beats("post_abort_no_write");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
